// File: rtl/serial_adder_n.sv
// serial_adder_n: multi-cycle adder computing a + b + cin, BITS_PER_CYCLE bits per clock, LSB chunk first.
// Optional subtract mode (adds input port sub) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_n #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (WIDTH < 2 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_param
    $error("serial_adder_n: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                      state;
  logic [WIDTH-1:0]            a_sh;
  logic [WIDTH-1:0]            b_sh;
  logic [WIDTH-1:0]            acc;
  logic                        carry;
  logic [CW-1:0]               step;
  logic [BITS_PER_CYCLE-1:0]   chunk_sum;
  logic [BITS_PER_CYCLE:0]     c;
  logic [WIDTH+BITS_PER_CYCLE-1:0] acc_cat;
  logic [WIDTH-1:0]            acc_next;
  logic                        b_inv;
  logic                        c_init;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction folds into the adder as a + ~b + 1; cin is ignored in that mode.
  assign b_inv  = sub;
  assign c_init = sub | cin;
`else
  assign b_inv  = 1'b0;
  assign c_init = cin;
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  assign c[0] = carry;
  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_fa
    assign chunk_sum[gi] = a_sh[gi] ^ b_sh[gi] ^ c[gi];
    assign c[gi+1]       = (a_sh[gi] & b_sh[gi]) | (c[gi] & (a_sh[gi] ^ b_sh[gi]));
  end

  // New chunk enters from the MSB side; works for STEPS=1 as well.
  assign acc_cat  = {chunk_sum, acc};
  assign acc_next = acc_cat[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      step      <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b ^ {WIDTH{b_inv}};
            carry <= c_init;
            step  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> BITS_PER_CYCLE;
          b_sh  <= b_sh >> BITS_PER_CYCLE;
          carry <= c[BITS_PER_CYCLE];
          acc   <= acc_next;
          step  <= step + 1'b1;
          if (step == LAST) begin
            sum       <= acc_next;
            cout      <= c[BITS_PER_CYCLE];
            ovf       <= c[BITS_PER_CYCLE] ^ c[BITS_PER_CYCLE-1];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_n.sv
// tb_serial_adder_n: directed and swept checks of serial_adder_n (8x1, 16x4, and 8x2 subtract when enabled).
module tb_serial_adder_n;
  logic        clk;
  logic        rst_n;
  logic [2:0]  in_valid_v;
  logic [2:0]  out_ready_v;
  logic [2:0]  cin_v;
  logic [15:0] a_v [3];
  logic [15:0] b_v [3];
`ifdef SERIAL_ADDER_SUB_EN
  logic [2:0]  sub_v;
`endif

  logic        in_ready8, out_valid8, cout8, ovf8, busy8;
  logic [7:0]  sum8;
  logic        in_ready16, out_valid16, cout16, ovf16, busy16;
  logic [15:0] sum16;

  logic [2:0]  in_ready_w, out_valid_w, cout_w, ovf_w, busy_w;
  logic [15:0] sum_w [3];

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_adder_n #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_add8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready8),
    .a(a_v[0][7:0]), .b(b_v[0][7:0]), .cin(cin_v[0]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_v[0]),
`endif
    .out_valid(out_valid8), .out_ready(out_ready_v[0]), .sum(sum8),
    .cout(cout8), .ovf(ovf8), .busy(busy8)
  );

  serial_adder_n #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_add16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready16),
    .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_v[1]),
`endif
    .out_valid(out_valid16), .out_ready(out_ready_v[1]), .sum(sum16),
    .cout(cout16), .ovf(ovf16), .busy(busy16)
  );

`ifdef SERIAL_ADDER_SUB_EN
  logic       in_ready_s, out_valid_s, cout_s, ovf_s, busy_s;
  logic [7:0] sum_s;

  serial_adder_n #(.WIDTH(8), .BITS_PER_CYCLE(2)) u_sub8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_s),
    .a(a_v[2][7:0]), .b(b_v[2][7:0]), .cin(cin_v[2]), .sub(sub_v[2]),
    .out_valid(out_valid_s), .out_ready(out_ready_v[2]), .sum(sum_s),
    .cout(cout_s), .ovf(ovf_s), .busy(busy_s)
  );
  assign in_ready_w  = {in_ready_s,  in_ready16,  in_ready8};
  assign out_valid_w = {out_valid_s, out_valid16, out_valid8};
  assign cout_w      = {cout_s,      cout16,      cout8};
  assign ovf_w       = {ovf_s,       ovf16,       ovf8};
  assign busy_w      = {busy_s,      busy16,      busy8};
  assign sum_w[2]    = {8'h00, sum_s};
`else
  assign in_ready_w  = {1'b0, in_ready16,  in_ready8};
  assign out_valid_w = {1'b0, out_valid16, out_valid8};
  assign cout_w      = {1'b0, cout16,      cout8};
  assign ovf_w       = {1'b0, ovf16,       ovf8};
  assign busy_w      = {1'b0, busy16,      busy8};
  assign sum_w[2]    = 16'h0000;
`endif
  assign sum_w[0] = {8'h00, sum8};
  assign sum_w[1] = sum16;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present operands on instance k and leave the bench 1 time unit after the accept edge.
  task automatic start_op(input int k, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input string tag);
    int wait_cyc;
    wait_cyc = 0;
    while (!in_ready_w[k] && wait_cyc < 50) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    check({tag, " in_ready"}, 32'(in_ready_w[k]), 32'd1);
    a_v[k] = a;
    b_v[k] = b;
    cin_v[k] = cin;
`ifdef SERIAL_ADDER_SUB_EN
    sub_v[k] = sub;
`else
    if (sub) $display("note: sub requested but subtract mode not built");
`endif
    in_valid_v[k] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[k] = 1'b0;
    a_v[k] = 16'($urandom);
    b_v[k] = 16'($urandom);
    cin_v[k] = ~cin;
  endtask

  task automatic op(input int k, input logic [15:0] a, input logic [15:0] b, input logic cin,
                    input logic sub, input int exp_lat, input logic [15:0] exp_sum,
                    input logic exp_cout, input logic exp_ovf, input int stall, input string tag);
    int lat;
    start_op(k, a, b, cin, sub, tag);
    lat = 0;
    while (!out_valid_w[k] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, {14'h0, cout_w[k], ovf_w[k], sum_w[k]},
          {14'h0, exp_cout, exp_ovf, exp_sum});
    // Stall in DONE while waving in_valid and operands around.
    for (int s = 0; s < stall; s++) begin
      in_valid_v[k] = ~in_valid_v[k];
      a_v[k] = 16'($urandom);
      b_v[k] = 16'($urandom);
      @(posedge clk); #1;
      check({tag, " hold"}, {12'h0, out_valid_w[k], in_ready_w[k], busy_w[k], cout_w[k], ovf_w[k], sum_w[k]},
            {12'h0, 1'b1, 1'b0, 1'b1, exp_cout, exp_ovf, exp_sum});
    end
    in_valid_v[k] = 1'b0;
    out_ready_v[k] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[k] = 1'b0;
    check({tag, " release"}, {29'h0, out_valid_w[k], in_ready_w[k], busy_w[k]}, 32'b010);
  endtask

  initial begin
    logic [16:0] full;
    logic [15:0] ra, rb;
    logic        rc, rovf;

    rst_n = 1'b0;
    in_valid_v = '0;
    out_ready_v = '0;
    cin_v = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub_v = '0;
`endif
    for (int k = 0; k < 3; k++) begin
      a_v[k] = '0;
      b_v[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset8", {13'h0, out_valid8, in_ready8, busy8, cout8, ovf8, 8'h00, sum8}, {13'h0, 5'b01000, 16'h0000});
    check("reset16", {13'h0, out_valid16, in_ready16, busy16, cout16, ovf16, sum16}, {13'h0, 5'b01000, 16'h0000});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op(0, 16'h00, 16'h00, 1'b0, 1'b0, 8, 16'h00, 1'b0, 1'b0, 0, "zero");
    op(0, 16'hFF, 16'h01, 1'b0, 1'b0, 8, 16'h00, 1'b1, 1'b0, 0, "ff+01");
    op(0, 16'h7F, 16'h01, 1'b0, 1'b0, 8, 16'h80, 1'b0, 1'b1, 0, "7f+01");
    op(0, 16'h80, 16'h80, 1'b1, 1'b0, 8, 16'h01, 1'b1, 1'b1, 0, "80+80+1");
    op(0, 16'h3C, 16'h0A, 1'b1, 1'b0, 8, 16'h47, 1'b0, 1'b0, 5, "backpressure");
    @(posedge clk); #1;
    check("no_accept", {30'h0, busy8, in_ready8}, 32'b01);

    // Abort an operation three RUN cycles in.
    start_op(0, 16'h55, 16'h0F, 1'b0, 1'b0, "abort");
    repeat (3) @(posedge clk);
    #1;
    check("abort busy", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort reset", {22'h0, out_valid8, in_ready8, busy8, cout8, ovf8, sum8}, {22'h0, 5'b01000, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    op(0, 16'h12, 16'h34, 1'b0, 1'b0, 8, 16'h46, 1'b0, 1'b0, 0, "after_reset");

    op(1, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 4, 16'h0001, 1'b1, 1'b0, 0, "w16 ffff+1+1");
    op(1, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 4, 16'h8000, 1'b0, 1'b1, 2, "w16 7fff+0+1");
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
      rovf = (ra[15] == rb[15]) && (full[15] != ra[15]);
      op(1, ra, rb, rc, 1'b0, 4, full[15:0], full[16], rovf, int'($urandom_range(0, 3)),
         $sformatf("rnd%0d", i));
    end

`ifdef SERIAL_ADDER_SUB_EN
    op(2, 16'h05, 16'h07, 1'b0, 1'b1, 4, 16'hFE, 1'b0, 1'b0, 0, "sub 05-07");
    op(2, 16'h80, 16'h01, 1'b1, 1'b1, 4, 16'h7F, 1'b1, 1'b1, 0, "sub 80-01");
    op(2, 16'h05, 16'h07, 1'b0, 1'b0, 4, 16'h0C, 1'b0, 1'b0, 0, "add 05+07");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/serial_adder_n.md
Name: serial_adder_n

Overview:
- Parametrised multi-cycle adder; successor to the team's one-bit full-adder cells.
- Adds two WIDTH-bit operands plus carry-in, BITS_PER_CYCLE bits per clock, least significant chunk first.
- Uses a valid/ready handshake on both input and output, so it drops into streaming datapaths where area matters more than latency.

Parameters:
WIDTH, 8, operand and sum width in bits (>=2)
BITS_PER_CYCLE, 1, bits added per RUN cycle; must divide WIDTH exactly, otherwise elaboration fails
(derived) STEPS = WIDTH/BITS_PER_CYCLE, number of RUN cycles per operation

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands present on a, b, cin
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in
out_valid  output  1  sum, cout and ovf are valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result, LSB = bit 0
cout  output  1  carry out of bit WIDTH-1
ovf  output  1  two's-complement signed overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - Registered outputs: out_valid=0, sum=0, cout=0, ovf=0.
  - State = IDLE, so in_ready=1 and busy=0. Both are decoded combinationally from state.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: capture a, b and cin into internal shift registers, clear the step counter, go to RUN.
- RUN:
  - Each cycle, add the low BITS_PER_CYCLE bits of the A and B shifters plus the running carry using a ripple of full-adder cells.
  - Shift the chunk result into the sum register from the MSB side. Shift the A and B shifters right by BITS_PER_CYCLE.
  - The running carry register holds the chunk carry-out.
  - On the edge that processes chunk STEPS-1:
    - Load sum, cout = final carry, and ovf = carry into MSB XOR carry out of MSB.
    - Set out_valid=1 and go to DONE.
- Latency: out_valid rises STEPS clock edges after the accepting edge (8 for the defaults).
- DONE:
  - out_valid=1. sum, cout and ovf are held stable while out_ready=0.
  - in_valid is ignored; in_ready=0.
  - On out_ready=1: clear out_valid and go to IDLE. in_ready rises in the same cycle out_valid falls; there is no same-cycle result-to-accept bypass.
- Sustained throughput: one result per STEPS+2 cycles when out_ready is held high.
- Operand stability: inputs are sampled only on the accept edge. a and b may change freely afterwards.
- Outputs outside DONE:
  - sum, cout and ovf keep their last values; do not rely on them when out_valid=0.
  - They are cleared only by reset.
- Reset mid-operation: rst_n low at any time aborts immediately. All registers return to reset values and the partial result is discarded. The first accept after reset produces a correct result.
- Width rules:
  - The internal carry is 1 bit between chunks.
  - The step counter is clog2(STEPS) bits wide, minimum 1.
  - STEPS=1 (BITS_PER_CYCLE=WIDTH) is legal: single RUN cycle, latency 1.

Optional Feature:
SERIAL_ADDER_SUB_EN
- Defined:
  - Adds input port sub (1 bit), sampled with the operands on accept.
  - sub=1 computes a - b as a + ~b + 1; cin is ignored.
  - cout=1 means no borrow (a >= b unsigned); ovf is the signed overflow of the subtraction.
  - sub=0 behaves exactly as the base block.
- Undefined: the sub port is absent and the block only adds.

Test Plan:
1. WIDTH=8, BPC=1: a=0x00, b=0x00, cin=0 -> out_valid exactly 8 edges after accept; sum=0x00, cout=0, ovf=0.
2. WIDTH=8, BPC=1: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80, cin=1 -> sum=0x01, cout=1, ovf=1.
3. Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a/b -> sum, cout and ovf are stable, in_ready=0, no new accept. Raise out_ready -> IDLE next cycle, in_ready=1.
4. Reset mid-run: deassert rst_n after 3 RUN cycles -> out_valid=0, sum=0, in_ready=1 immediately. Release reset, then send a=0x12, b=0x34 -> sum=0x46, cout=0.
5. WIDTH=16, BPC=4: a=0xFFFF, b=0x0001, cin=1 -> sum=0x0001, cout=1, out_valid 4 edges after accept. Also run a random sweep of 1000 operand pairs against a reference a+b+cin model with random out_ready stalls.
6. With SERIAL_ADDER_SUB_EN, WIDTH=8, BPC=2: sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0, ovf=0. Then sub=1, a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
